// File: rtl/lvds_rx_word_fifo.sv
// LVDS receive word framer and FWFT FIFO.
// Re-frames the aligned byte stream into 32-bit words (MSB first) after the
// sync marker, optionally drops idle filler words, and buffers words for a
// dequeue handshake. Head word and ready flag are registered.
module lvds_rx_word_fifo #(
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned AW        = 3,
    parameter logic [7:0]  SYNC_BYTE = 8'h77,
    parameter logic [31:0] IDLE_WORD = 32'h52525252,
    parameter bit          DROP_IDLE = 1'b1
) (
    input  logic          rx_inclock,
    input  logic          pll_areset,
    input  logic          rx_align_done,
    input  logic [7:0]    rx_out,
    output logic [31:0]   deq_rx_get,
    output logic          RDY_deq_rx_get,
    input  logic          EN_deq_rx_get,
    output logic [AW:0]   fifo_count,
    output logic          overflow
);

    localparam int unsigned CW = AW + 1;

    typedef enum logic [2:0] {
        S_WAIT,
        S_HUNT,
        S_B0,
        S_B1,
        S_B2,
        S_B3
    } state_t;

    state_t          state;
    logic [31:8]     word_q;
    logic [31:0]     mem [DEPTH];
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;

    logic [31:0]     word_done_c;
    logic            push_req_c;
    logic            pop_c;
    logic            full_c;
    logic            push_ok_c;
    logic [AW-1:0]   rd_next_c;
    logic [CW-1:0]   count_next_c;
    logic [31:0]     head_next_c;

    // Push/pop decisions and the head word seen after this edge.
    always_comb begin
        word_done_c  = {word_q, rx_out};
        push_req_c   = 1'b0;
        pop_c        = EN_deq_rx_get && RDY_deq_rx_get;
        full_c       = (fifo_count == CW'(DEPTH));
        push_ok_c    = 1'b0;
        rd_next_c    = rd_ptr;
        count_next_c = fifo_count;
        head_next_c  = 32'h0;

        if (rx_align_done && (state == S_B3)) begin
            push_req_c = !(DROP_IDLE && (word_done_c == IDLE_WORD));
        end
        push_ok_c = push_req_c && (!full_c || pop_c);

        if (pop_c) begin
            rd_next_c = rd_ptr + AW'(1);
        end
        count_next_c = fifo_count + CW'(push_ok_c) - CW'(pop_c);

        // A word written this edge into the slot that becomes the head must
        // bypass storage, since storage is only updated at the same edge.
        if (count_next_c != '0) begin
            if (push_ok_c && (rd_next_c == wr_ptr)) begin
                head_next_c = word_done_c;
            end else begin
                head_next_c = mem[rd_next_c];
            end
        end
    end

    // Framing FSM and byte assembly; loss of alignment wins over everything.
    always_ff @(posedge rx_inclock or posedge pll_areset) begin
        if (pll_areset) begin
            state  <= S_WAIT;
            word_q <= '0;
        end else if (!rx_align_done) begin
            state  <= S_WAIT;
            word_q <= '0;
        end else begin
            case (state)
                S_WAIT: state <= S_HUNT;
                S_HUNT: begin
                    if (rx_out == SYNC_BYTE) begin
                        state <= S_B0;
                    end
                end
                S_B0: begin
                    word_q[31:24] <= rx_out;
                    state         <= S_B1;
                end
                S_B1: begin
                    word_q[23:16] <= rx_out;
                    state         <= S_B2;
                end
                S_B2: begin
                    word_q[15:8] <= rx_out;
                    state        <= S_B3;
                end
                S_B3: state <= S_B0;
                default: state <= S_WAIT;
            endcase
        end
    end

    // Word storage; contents need no reset.
    always_ff @(posedge rx_inclock) begin
        if (push_ok_c) begin
            mem[wr_ptr] <= word_done_c;
        end
    end

    // Pointers, occupancy, registered head/ready and sticky overflow.
    always_ff @(posedge rx_inclock or posedge pll_areset) begin
        if (pll_areset) begin
            rd_ptr         <= '0;
            wr_ptr         <= '0;
            fifo_count     <= '0;
            RDY_deq_rx_get <= 1'b0;
            deq_rx_get     <= 32'h0;
            overflow       <= 1'b0;
        end else begin
            rd_ptr         <= rd_next_c;
            fifo_count     <= count_next_c;
            RDY_deq_rx_get <= (count_next_c != '0);
            deq_rx_get     <= head_next_c;
            if (push_ok_c) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (push_req_c && !push_ok_c) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule
